// File: rtl/sprite_layer_pkg.sv
// Shared screen constants, colour channel width and the 12-bit colour type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_layer_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int CH_W     = 4;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb12_t;

  // Counter width that stays legal when the range collapses to a single value.
  function automatic int cbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_palette.sv
// Maps a sprite palette index to a 12-bit colour.
// Latency: combinational.
// Backpressure: none, pure lookup.
module sprite_palette
  import sprite_layer_pkg::*;
#(
  parameter int IDX_BITS = 2
) (
  input  logic [IDX_BITS-1:0] idx,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue
);

  logic [7:0] idx8;
  rgb12_t     colour;

  // Fixed four-entry table; wider indices get a colour derived from their bits.
  always_comb begin
    idx8 = 8'(idx);
    case (idx8)
      8'd0:    colour = 12'h000;
      8'd1:    colour = 12'hF80;
      8'd2:    colour = 12'h0CF;
      8'd3:    colour = 12'hFFF;
      default: colour = {idx8[3:0], ~idx8[3:0], idx8[7:4]};
    endcase
  end

  assign red   = colour.r;
  assign green = colour.g;
  assign blue  = colour.b;

endmodule

// File: rtl/sprite_layer.sv
// Scaled, animated, optionally mirrored sprite composited over a background layer.
// Latency: 2 vga_clk cycles from DrawX/DrawY to colour; rom_addr is combinational.
// Backpressure: none, the pixel stream is clock-locked and never stalls.
module sprite_layer
  import sprite_layer_pkg::*;
#(
  parameter int SPRITE_W    = 28,
  parameter int SPRITE_H    = 68,
  parameter int FRAMES      = 4,
  parameter int SCALE_SHIFT = 1,
  parameter int IDX_BITS    = 2,
  parameter int TRANSP_IDX  = 0,
  parameter int ANIM_DIV    = 8,
  localparam int AW         = $clog2(FRAMES*SPRITE_W*SPRITE_H)
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                blank,
  input  logic                frame_start,
  input  logic [9:0]          pos_x,
  input  logic [9:0]          pos_y,
  input  logic                flip_h,
  input  logic                show,
  input  logic                anim_en,
  input  logic [CH_W-1:0]     bg_red,
  input  logic [CH_W-1:0]     bg_green,
  input  logic [CH_W-1:0]     bg_blue,
  output logic [AW-1:0]       rom_addr,
  input  logic [IDX_BITS-1:0] rom_data,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  output logic                hit
);

  localparam int BOX_W = SPRITE_W << SCALE_SHIFT;
  localparam int BOX_H = SPRITE_H << SCALE_SHIFT;
  localparam int FW    = cbits(FRAMES);
  localparam int CW    = cbits(ANIM_DIV);

  logic [9:0]      px_q, py_q;
  logic            flip_q, show_q;
  logic [CW-1:0]   anim_cnt;
  logic [FW-1:0]   frame_idx;
  logic [10:0]     dx, dy, col_raw, col, row;
  logic            in_box;
  logic            s1_blank, s1_vis;
  rgb12_t          s1_bg;
  logic [CH_W-1:0] pal_r, pal_g, pal_b;

  // Placement is sampled once per video frame so the sprite never tears mid-frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      px_q   <= '0;
      py_q   <= '0;
      flip_q <= 1'b0;
      show_q <= 1'b0;
    end else if (frame_start) begin
      px_q   <= pos_x;
      py_q   <= pos_y;
      flip_q <= flip_h;
      show_q <= show;
    end
  end

  // Animation advances one frame every ANIM_DIV enabled frame_start pulses.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      anim_cnt  <= '0;
      frame_idx <= '0;
    end else if (frame_start && anim_en) begin
      if (anim_cnt == CW'(ANIM_DIV-1)) begin
        anim_cnt  <= '0;
        frame_idx <= (frame_idx == FW'(FRAMES-1)) ? '0 : frame_idx + FW'(1);
      end else begin
        anim_cnt <= anim_cnt + CW'(1);
      end
    end
  end

  // 11-bit offsets: a pixel left of or above the corner goes hugely positive, so
  // one unsigned compare rejects it and sprites past column 1023 never wrap.
  always_comb begin
    dx       = {1'b0, DrawX} - {1'b0, px_q};
    dy       = {1'b0, DrawY} - {1'b0, py_q};
    in_box   = (dx < 11'(BOX_W)) && (dy < 11'(BOX_H));
    col_raw  = dx >> SCALE_SHIFT;
    col      = flip_q ? (11'(SPRITE_W-1) - col_raw) : col_raw;
    row      = dy >> SCALE_SHIFT;
    rom_addr = '0;
    if (in_box)
      rom_addr = AW'(32'(frame_idx) * 32'(SPRITE_W*SPRITE_H)
                   + 32'(row) * 32'(SPRITE_W) + 32'(col));
  end

  // Stage 1: carry pixel context alongside the ROM read in flight.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_blank <= 1'b0;
      s1_vis   <= 1'b0;
      s1_bg    <= '0;
    end else begin
      s1_blank <= blank;
      s1_vis   <= in_box & show_q;
      s1_bg    <= '{r: bg_red, g: bg_green, b: bg_blue};
    end
  end

  sprite_palette #(.IDX_BITS(IDX_BITS)) u_palette (
    .idx   (rom_data),
    .red   (pal_r),
    .green (pal_g),
    .blue  (pal_b)
  );

  // Stage 2: blanking wins, then an opaque sprite texel, else the background.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hit   <= 1'b0;
    end else if (!s1_blank) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hit   <= 1'b0;
    end else if (s1_vis && (rom_data != IDX_BITS'(TRANSP_IDX))) begin
      red   <= pal_r;
      green <= pal_g;
      blue  <= pal_b;
      hit   <= 1'b1;
    end else begin
      red   <= s1_bg.r;
      green <= s1_bg.g;
      blue  <= s1_bg.b;
      hit   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_layer.sv
// Scoreboard bench for sprite_layer against a plain-arithmetic reference model.
// Latency: expectations are due two cycles after the pixel is driven.
// Backpressure: none; the ROM model answers one cycle after each address.
module tb_sprite_layer;

  localparam int SW = 28;
  localparam int SH = 68;
  localparam int FR = 4;
  localparam int SS = 1;
  localparam int IB = 2;
  localparam int TI = 0;
  localparam int AD = 8;
  localparam int ROM_N = FR*SW*SH;
  localparam int AW = $clog2(ROM_N);

  typedef struct {
    int         due;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       h;
  } exp_t;

  logic          vga_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [9:0]    DrawX = '0, DrawY = '0;
  logic          blank = 1'b0, frame_start = 1'b0;
  logic [9:0]    pos_x = '0, pos_y = '0;
  logic          flip_h = 1'b0, show = 1'b0, anim_en = 1'b0;
  logic [3:0]    bg_red = '0, bg_green = '0, bg_blue = '0;
  logic [AW-1:0] rom_addr;
  logic [IB-1:0] rom_data;
  logic [3:0]    red, green, blue;
  logic          hit;

  logic [IB-1:0] rom_mem [ROM_N];
  exp_t          sbq[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;

  // values presented to the DUT on the next driven cycle
  int            n_px, n_py;
  bit            n_flip, n_show, n_anim;
  logic [11:0]   n_bg;
  // reference model state
  int            m_px, m_py, m_nen;
  bit            m_flip, m_show;

  sprite_layer #(
    .SPRITE_W(SW), .SPRITE_H(SH), .FRAMES(FR), .SCALE_SHIFT(SS),
    .IDX_BITS(IB), .TRANSP_IDX(TI), .ANIM_DIV(AD)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
    .flip_h(flip_h), .show(show), .anim_en(anim_en),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .red(red), .green(green), .blue(blue), .hit(hit)
  );

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc++;
  always @(posedge vga_clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [11:0] ref_pal(input int idx);
    case (idx)
      1:       return 12'hF80;
      2:       return 12'h0CF;
      3:       return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  task automatic model_reset();
    m_px = 0; m_py = 0; m_nen = 0; m_flip = 0; m_show = 0;
  endtask

  task automatic drive(input int x, input int y, input bit bl, input bit fs);
    int dx, dy, col, row, a, fidx, idx;
    bit inb;
    logic [11:0] c;
    exp_t e;
    @(negedge vga_clk);
    DrawX = 10'(x); DrawY = 10'(y); blank = bl; frame_start = fs;
    pos_x = 10'(n_px); pos_y = 10'(n_py);
    flip_h = n_flip; show = n_show; anim_en = n_anim;
    {bg_red, bg_green, bg_blue} = n_bg;
    dx = x - m_px;
    dy = y - m_py;
    inb = (dx >= 0) && (dx < SW*(1<<SS)) && (dy >= 0) && (dy < SH*(1<<SS));
    fidx = (m_nen / AD) % FR;
    col = dx / (1<<SS);
    row = dy / (1<<SS);
    if (m_flip) col = SW - 1 - col;
    a = inb ? (fidx*SW*SH + row*SW + col) : 0;
    idx = int'(rom_mem[a]);
    e.h = 1'b0;
    if (!bl) c = 12'h000;
    else if (inb && m_show && idx != TI) begin c = ref_pal(idx); e.h = 1'b1; end
    else c = n_bg;
    e.r = c[11:8]; e.g = c[7:4]; e.b = c[3:0];
    e.due = cyc + 2;
    sbq.push_back(e);
    if (fs) begin
      m_px = n_px; m_py = n_py; m_flip = n_flip; m_show = n_show;
      if (n_anim) m_nen++;
    end
    #1 check("rom_addr", 32'(rom_addr), 32'(a));
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_red"}, 32'(red), 0);
    check({tag, "_green"}, 32'(green), 0);
    check({tag, "_blue"}, 32'(blue), 0);
    check({tag, "_hit"}, 32'(hit), 0);
  endtask

  // Called just after a drive returns: reset lands between clock edges.
  task automatic mid_reset();
    #2;
    reset_n = 1'b0;
    frame_start = 1'b0;
    #1 outputs_zero("midreset");
    sbq.delete();
    model_reset();
    @(negedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  // Monitor: compare every expectation in the cycle it falls due.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge vga_clk);
      #2;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        check("sb_due", 32'(e.due), 32'(cyc));
        check("sb_red", 32'(red), 32'(e.r));
        check("sb_green", 32'(green), 32'(e.g));
        check("sb_blue", 32'(blue), 32'(e.b));
        check("sb_hit", 32'(hit), 32'(e.h));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int x, y;
    for (int i = 0; i < ROM_N; i++) rom_mem[i] = IB'($urandom);
    rom_mem[0] = 2'd1;  rom_mem[1] = 2'(TI); rom_mem[27] = 2'd2;
    rom_mem[28] = 2'd3; rom_mem[11] = 2'd3;  rom_mem[1904] = 2'd1;
    model_reset();
    n_px = 100; n_py = 50; n_flip = 0; n_show = 1; n_anim = 0; n_bg = 12'h35A;

    repeat (2) @(negedge vga_clk);
    #1 outputs_zero("reset");
    @(negedge vga_clk);
    reset_n = 1'b1;

    // before the first frame_start the sprite is hidden
    drive(10, 10, 1, 0);
    drive(20, 30, 1, 0);
    drive(0, 0, 0, 1);
    drive(100, 50, 1, 0);  check("addr_origin", 32'(rom_addr), 0);
    drive(103, 50, 1, 0);  check("addr_col1", 32'(rom_addr), 1);
    drive(100, 52, 1, 0);  check("addr_row1", 32'(rom_addr), 28);
    drive(102, 51, 0, 0);
    // placement change without frame_start has no effect
    n_px = 200; n_py = 200;
    drive(100, 50, 1, 0);  check("addr_hold0", 32'(rom_addr), 0);
    drive(103, 50, 1, 0);  check("addr_hold1", 32'(rom_addr), 1);
    // horizontal mirror
    n_px = 100; n_py = 50; n_flip = 1;
    drive(0, 0, 0, 1);
    drive(100, 50, 1, 0);  check("flip_left", 32'(rom_addr), 27);
    drive(155, 50, 1, 0);  check("flip_right", 32'(rom_addr), 0);
    drive(156, 50, 1, 0);  check("flip_outside", 32'(rom_addr), 0);
    // right-edge sprite does not wrap to column 0
    n_flip = 0; n_px = 1000;
    drive(0, 0, 0, 1);
    drive(1023, 50, 1, 0); check("edge_col11", 32'(rom_addr), 11);
    drive(5, 50, 1, 0);    check("edge_nowrap", 32'(rom_addr), 0);
    // opaque pixels, then reset in the middle of the line
    n_px = 100;
    drive(0, 0, 0, 1);
    drive(100, 50, 1, 0);
    drive(100, 50, 1, 0);
    drive(100, 50, 1, 0);
    mid_reset();
    drive(0, 0, 1, 0);
    drive(10, 10, 1, 0);
    drive(100, 50, 1, 0);
    drive(0, 0, 0, 1);
    drive(100, 50, 1, 0);
    // animation: eight enabled pulses step one frame, 32 wrap around
    n_anim = 1;
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1);
    n_anim = 0;
    drive(100, 50, 1, 0);  check("anim_frame1", 32'(rom_addr), 1904);
    n_anim = 1;
    for (int i = 0; i < 24; i++) drive(0, 0, 0, 1);
    n_anim = 0;
    drive(100, 50, 1, 0);  check("anim_wrap", 32'(rom_addr), 0);

    // randomized traffic around the sprite
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) n_px = int'($urandom_range(980, 1023));
      else n_px = int'($urandom_range(0, 1023));
      n_py = int'($urandom_range(0, 1023));
      n_flip = 1'($urandom);
      n_show = ($urandom_range(0, 3) != 0);
      n_anim = 1'($urandom);
      n_bg = 12'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        x = int'($urandom_range(0, 1023));
        y = int'($urandom_range(0, 1023));
      end else begin
        x = (m_px + int'($urandom_range(0, 70)) - 6) & 1023;
        y = (m_py + int'($urandom_range(0, 150)) - 6) & 1023;
      end
      drive(x, y, ($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0));
    end

    @(negedge vga_clk);
    frame_start = 1'b0;
    repeat (4) @(negedge vga_clk);
    check("sb_drained", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_layer.md
SPRITE_LAYER -- requirements
Module: sprite_layer

Interface
REQ-001 SHALL have parameter SPRITE_W, default 28, sprite width in texels.
REQ-002 SHALL have parameter SPRITE_H, default 68, sprite height in texels.
REQ-003 SHALL have parameter FRAMES, default 4, animation frames stored back-to-back in ROM.
REQ-004 SHALL have parameter SCALE_SHIFT, default 1, on-screen magnification of 2^SCALE_SHIFT.
REQ-005 SHALL have parameter IDX_BITS, default 2, palette index width; parameter TRANSP_IDX, default 0, transparent index.
REQ-006 SHALL have parameter ANIM_DIV, default 8, video frames per animation step (>=1).
REQ-007 vga_clk  in  1  pixel clock; all logic on posedge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 DrawX, DrawY  in  10 each  current pixel coordinate.
REQ-010 blank  in  1  high = active display region.
REQ-011 frame_start  in  1  one-cycle pulse at start of each video frame.
REQ-012 pos_x, pos_y  in  10 each  requested sprite top-left corner.
REQ-013 flip_h, show, anim_en  in  1 each  mirror horizontally / sprite visible / animation running.
REQ-014 bg_red, bg_green, bg_blue  in  4 each  underlying layer colour, aligned with DrawX.
REQ-015 rom_addr  out  clog2(FRAMES*SPRITE_W*SPRITE_H)  texel address to external synchronous ROM.
REQ-016 rom_data  in  IDX_BITS  ROM index, valid one cycle after rom_addr.
REQ-017 red, green, blue  out  4 each  composited colour; hit  out  1  opaque sprite texel drawn.

Function
REQ-018 pos_x, pos_y, flip_h, show SHALL be sampled only on cycles with frame_start=1; held values used for the whole frame (no mid-frame tearing).
REQ-019 in_box SHALL be true when DrawX-px in [0, SPRITE_W<<SCALE_SHIFT) and DrawY-py in [0, SPRITE_H<<SCALE_SHIFT), compared at 11 bits, no wrap for sprites extending past 1023.
REQ-020 col = (DrawX-px)>>SCALE_SHIFT, replaced by SPRITE_W-1-col when flip_h latched; row = (DrawY-py)>>SCALE_SHIFT.
REQ-021 rom_addr SHALL equal frame_idx*SPRITE_W*SPRITE_H + row*SPRITE_W + col, combinational from current inputs; 0 when not in_box.
REQ-022 Anim counter SHALL count frame_start pulses when anim_en=1; on reaching ANIM_DIV-1 it clears and frame_idx increments, wrapping FRAMES-1 -> 0.
REQ-023 anim_en=0 SHALL freeze counter and frame_idx; frame_idx changes only on a frame_start cycle.
REQ-024 Pipeline latency SHALL be exactly 2 cycles: inputs at cycle t -> red/green/blue/hit at t+2; blank, in_box, show and bg colour delayed to match.
REQ-025 Palette SHALL map rom_data to 12-bit RGB combinationally in stage 2.
REQ-026 At t+2: blank=0 -> rgb=0, hit=0; else if in_box & show & rom_data!=TRANSP_IDX -> palette colour, hit=1; else bg colour, hit=0.
REQ-027 frame_start and sprite pixels on the same cycle SHALL use the pre-latch values for that pixel, new values from next cycle.

Reset
REQ-028 reset_n=0 SHALL asynchronously clear red/green/blue/hit, all pipeline registers, anim counter, frame_idx, latched pos/flip/show to 0.
REQ-029 First frame_start after reset release SHALL load positions; before it, output is bg colour (show=0).
REQ-030 Reset mid-frame SHALL produce no hit until the next frame_start.

Structure
REQ-031 Shared package SHALL hold screen constants (640, 480), 4-bit colour channel width and an rgb12 struct typedef.
REQ-032 Palette SHALL be a sub-module sprite_palette (index in, red/green/blue out); ROM stays external.

Verification
REQ-033 pos=(100,50), show=1, SCALE_SHIFT=1, frame_start: DrawX=100,DrawY=50 -> rom_addr=0; DrawX=103 -> addr 1; output 2 cycles later.
REQ-034 flip_h=1, same pos: DrawX=100,DrawY=50 -> rom_addr=27; DrawX=155 -> 0; DrawX=156 -> in_box=0, bg passed, hit=0.
REQ-035 rom_data=TRANSP_IDX inside box -> bg colour, hit=0; blank=0 inside box -> rgb=0.
REQ-036 anim_en=1, ANIM_DIV=8: 8 frame_starts -> frame_idx 1, base address 1904; 32 frame_starts -> wraps to 0.
REQ-037 pos_x=1000: DrawX=1023 -> in_box=1, col=11; DrawX=5 -> in_box=0 (no wrap).
REQ-038 pos changed mid-frame without frame_start -> addresses unchanged; reset_n low mid-line -> outputs 0 immediately, hit stays 0 until the next frame_start.
